alu_ctrl_seq: RTL and testbench

Registered, parametrised ALU control sequencer sitting between instruction decode and the ALU. It maps opcode/function fields to ALU operation codes using the same encoding as the existing combinational ALU control. It adds a valid/ready handshake on both sides, one output pipeline register, and multi-cycle expansion of iterative shifts into a stream of single-bit-shift beats.

---
 rtl/alu_ctrl_pkg.sv | 69 ++++++
 rtl/alu_ctrl_decode.sv | 44 ++++
 rtl/alu_ctrl_seq.sv | 137 +++++++++++++
 tb/tb_alu_ctrl_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control path: op code constants, sequencer
// state type and the opcode/function decode used by legacy and sequenced control.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_AND     = 4'b0001;
    localparam logic [3:0] ALU_XOR     = 4'b0010;
    localparam logic [3:0] ALU_OR      = 4'b0011;
    localparam logic [3:0] ALU_SLT     = 4'b0100;
    localparam logic [3:0] ALU_SLTU    = 4'b0101;
    localparam logic [3:0] ALU_NOR     = 4'b0110;
    localparam logic [3:0] ALU_SUB     = 4'b0111;
    localparam logic [3:0] ALU_SHIFT1  = 4'b1110;
    localparam logic [3:0] ALU_SPECIAL = 4'b1111;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REPEAT = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       illegal;
        logic       expandable;
    } dec_t;

    // Any set bit above [3:0] in op (or in func when op is zero) is illegal.
    function automatic dec_t alu_decode(
        input logic [3:0] op_lo,
        input logic       op_hi_nz,
        input logic [3:0] func_lo,
        input logic       func_hi_nz
    );
        dec_t d;
        logic op_zero;
        d.aluop      = ALU_ADD;
        d.illegal    = 1'b0;
        d.expandable = 1'b0;
        op_zero      = (op_lo == 4'd0) && !op_hi_nz;
        if (op_hi_nz || (op_zero && func_hi_nz)) begin
            d.illegal = 1'b1;
        end else if (op_zero) begin
            case (func_lo)
                4'd0:        d.aluop = ALU_ADD;
                4'd1:        d.aluop = ALU_OR;
                4'd2:        d.aluop = ALU_AND;
                4'd3:        d.aluop = ALU_XOR;
                4'd4:        d.aluop = ALU_SLT;
                4'd8:        d.aluop = ALU_SPECIAL;
                4'd9, 4'd10: d.aluop = ALU_SHIFT1;
                default:     d.illegal = 1'b1;
            endcase
        end else begin
            case (op_lo)
                4'd2, 4'd3: d.aluop = ALU_SUB;
                4'd9:       d.aluop = ALU_AND;
                4'd10:      d.aluop = ALU_OR;
                4'd11:      d.aluop = ALU_SLT;
                4'd12:      d.aluop = ALU_SLTU;
                4'd13:      d.aluop = ALU_NOR;
                4'd15:      d.aluop = ALU_SPECIAL;
                default:    d.aluop = ALU_ADD;
            endcase
        end
        d.expandable = (d.aluop == ALU_SHIFT1) && !d.illegal;
        return d;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/function lookup; widens the 4-bit table code to ALUOP_W.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned FUNC_W  = 4,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNC_W-1:0]  func,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal,
    output logic               expandable
);

    logic w_op_hi_nz;
    logic w_func_hi_nz;
    dec_t w_dec;

    generate
        if (OP_W > 4) begin : g_op_hi
            assign w_op_hi_nz = |op[OP_W-1:4];
        end else begin : g_op_narrow
            assign w_op_hi_nz = 1'b0;
        end
        if (FUNC_W > 4) begin : g_func_hi
            assign w_func_hi_nz = |func[FUNC_W-1:4];
        end else begin : g_func_narrow
            assign w_func_hi_nz = 1'b0;
        end
    endgenerate

    assign w_dec = alu_decode(op[3:0], w_op_hi_nz, func[3:0], w_func_hi_nz);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        aluop      = '0;
        aluop[3:0] = w_dec.aluop;
    end

    assign illegal    = w_dec.illegal;
    assign expandable = w_dec.expandable;

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control sequencer: valid/ready on both sides, one output
// register, and expansion of iterative shifts into single-bit-shift beats.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned FUNC_W  = 4,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned EXPAND  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNC_W-1:0]  func,
    input  logic [CNT_W-1:0]   count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] aluop,
    output logic               last,
    output logic               illegal,
    output logic               busy
);

    seq_state_t         r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic               r_out_valid, w_out_valid_nx;
    logic [ALUOP_W-1:0] r_aluop, w_aluop_nx;
    logic               r_last, w_last_nx;
    logic               r_illegal, w_illegal_nx;

    logic [ALUOP_W-1:0] w_dec_aluop;
    logic [ALUOP_W-1:0] w_shift_op;
    logic               w_dec_illegal;
    logic               w_dec_expandable;
    logic               w_load;
    logic               w_accept;
    logic               w_expand;

    alu_ctrl_decode #(
        .OP_W    (OP_W),
        .FUNC_W  (FUNC_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .op         (op),
        .func       (func),
        .aluop      (w_dec_aluop),
        .illegal    (w_dec_illegal),
        .expandable (w_dec_expandable)
    );

    always_comb begin
        w_shift_op      = '0;
        w_shift_op[3:0] = ALU_SHIFT1;
    end

    // The output register may take a new beat when empty or being drained.
    assign w_load   = !r_out_valid || out_ready;
    assign in_ready = (r_state == S_IDLE) && w_load;
    assign w_accept = in_valid && in_ready;
    assign w_expand = (EXPAND != 0) && w_dec_expandable;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_out_valid_nx = r_out_valid;
        w_aluop_nx     = r_aluop;
        w_last_nx      = r_last;
        w_illegal_nx   = r_illegal;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_out_valid_nx = 1'b1;
                    w_aluop_nx     = w_dec_aluop;
                    w_illegal_nx   = w_dec_illegal;
                    w_last_nx      = 1'b1;
                    if (w_expand) begin
                        if (count == '0) begin
                            w_aluop_nx = '0;
                        end else if (count != CNT_W'(1)) begin
                            w_last_nx  = 1'b0;
                            w_cnt_nx   = count - CNT_W'(1);
                            w_state_nx = S_REPEAT;
                        end
                    end
                end else if (w_load) begin
                    w_out_valid_nx = 1'b0;
                end
            end
            S_REPEAT: begin
                // Counter holds the beats still to be loaded; it only moves on a load.
                if (w_load) begin
                    w_out_valid_nx = 1'b1;
                    w_aluop_nx     = w_shift_op;
                    w_illegal_nx   = 1'b0;
                    w_last_nx      = (r_cnt == CNT_W'(1));
                    w_cnt_nx       = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_aluop     <= '0;
            r_last      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_out_valid <= w_out_valid_nx;
            r_aluop     <= w_aluop_nx;
            r_last      <= w_last_nx;
            r_illegal   <= w_illegal_nx;
        end
    end

    assign out_valid = r_out_valid;
    assign aluop     = r_aluop;
    assign last      = r_last;
    assign illegal   = r_illegal;
    assign busy      = (r_state == S_REPEAT);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: table sweep through a scoreboard plus
// directed expansion, backpressure, back-to-back, reset and legacy-mode cases.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [3:0] op, func;
    logic [4:0] count;
    logic       out_valid, out_ready;
    logic [3:0] aluop;
    logic       last, illegal, busy;

    logic       in_valid2, in_ready2;
    logic [5:0] op2;
    logic [3:0] func2;
    logic [4:0] count2;
    logic       out_valid2, out_ready2;
    logic [3:0] aluop2;
    logic       last2, illegal2, busy2;

    int n_checks = 0;
    int n_err    = 0;
    int n_beats  = 0;
    bit mon_en   = 1'b0;

    typedef struct packed {
        logic [3:0] aluop;
        logic       last;
        logic       illegal;
    } beat_t;
    beat_t sb_q[$];

    typedef struct {
        logic [3:0] op;
        logic [3:0] func;
        logic [3:0] aluop;
        logic       illegal;
    } vec_t;
    vec_t vecs[31];

    always #5 clk = ~clk;

    alu_ctrl_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .func(func), .count(count), .out_valid(out_valid),
        .out_ready(out_ready), .aluop(aluop), .last(last),
        .illegal(illegal), .busy(busy)
    );

    alu_ctrl_seq #(.OP_W(6), .EXPAND(0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op2), .func(func2), .count(count2), .out_valid(out_valid2),
        .out_ready(out_ready2), .aluop(aluop2), .last(last2),
        .illegal(illegal2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats for one accepted request, derived from the bench tables.
    task automatic push_expect(input logic [3:0] ea, input logic ei, input logic [4:0] c);
        beat_t b;
        if (ea == 4'b1110 && !ei) begin
            if (c == 5'd0) begin
                b = '{aluop: 4'b0000, last: 1'b1, illegal: 1'b0};
                sb_q.push_back(b);
            end else begin
                for (int i = 1; i <= int'(c); i++) begin
                    b = '{aluop: 4'b1110, last: (i == int'(c)), illegal: 1'b0};
                    sb_q.push_back(b);
                end
            end
        end else begin
            b = '{aluop: ea, last: 1'b1, illegal: ei};
            sb_q.push_back(b);
        end
    endtask

    task automatic send(input logic [3:0] o, input logic [3:0] f, input logic [4:0] c,
                        input logic [3:0] ea, input logic ei, output int waited);
        waited = 0;
        @(negedge clk);
        op = o; func = f; count = c; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_expect(ea, ei, c);
            #1;
            in_valid = 1'b0;
            count    = 5'd17;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            beat_t b;
            n_beats++;
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                b = sb_q.pop_front();
                check("beat_aluop", aluop, b.aluop);
                check("beat_last", last, b.last);
                check("beat_illegal", illegal, b.illegal);
            end
        end
    end

    initial begin
        int op_exp[15]   = '{0, 7, 7, 0, 0, 0, 0, 0, 1, 3, 4, 5, 6, 0, 15};
        int func_exp[16] = '{0, 3, 1, 2, 4, 0, 0, 0, 15, 14, 14, 0, 0, 0, 0, 0};
        int w, base;
        logic [3:0] h_aluop;
        logic       h_last;

        for (int i = 0; i < 15; i++) begin
            vecs[i] = '{op: 4'(i + 1), func: 4'd0, aluop: 4'(op_exp[i]), illegal: 1'b0};
        end
        for (int i = 0; i < 16; i++) begin
            vecs[15 + i] = '{op: 4'd0, func: 4'(i), aluop: 4'(func_exp[i]),
                             illegal: ((i >= 5 && i <= 7) || i >= 11)};
        end

        reset = 1'b0; in_valid = 1'b0; op = '0; func = '0; count = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; op2 = '0; func2 = '0; count2 = '0; out_ready2 = 1'b1;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_aluop", aluop, 0);
        check("rst_last", last, 0);
        check("rst_illegal", illegal, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Table sweep with count=1 so the shift codes give one beat.
        for (int i = 0; i < 31; i++) begin
            send(vecs[i].op, vecs[i].func, 5'd1, vecs[i].aluop, vecs[i].illegal, w);
            @(negedge clk);
            check("sweep_latency_valid", out_valid, 1);
        end
        drain();

        // Expansion: three shift beats, busy and in_ready tracked.
        send(4'd0, 4'd9, 5'd3, 4'b1110, 1'b0, w);
        @(negedge clk);
        check("exp3_b1_busy", busy, 1);
        check("exp3_b1_in_ready", in_ready, 0);
        @(negedge clk);
        check("exp3_b2_busy", busy, 1);
        check("exp3_b2_in_ready", in_ready, 0);
        @(negedge clk);
        check("exp3_b3_last", last, 1);
        check("exp3_b3_busy", busy, 0);
        drain();

        send(4'd0, 4'd9, 5'd0, 4'b1110, 1'b0, w);
        @(negedge clk);
        check("cnt0_busy", busy, 0);
        drain();

        // Backpressure: out_ready low for beats 2-3 window.
        base = n_beats;
        send(4'd0, 4'd10, 5'd4, 4'b1110, 1'b0, w);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        h_aluop = aluop;
        h_last  = last;
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_hold_aluop", aluop, h_aluop);
            check("bp_hold_last", last, h_last);
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        check("bp_beat_count", n_beats - base, 4);
        check("bp_idle_busy", busy, 0);

        // Back-to-back: request waiting behind a 2-beat shift is taken as last drains.
        send(4'd0, 4'd10, 5'd2, 4'b1110, 1'b0, w);
        send(4'd9, 4'd0, 5'd0, 4'b0001, 1'b0, w);
        check("b2b_wait_cycles", w, 1);
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        check("b2b_aluop", aluop, 4'b0001);
        send(4'd10, 4'd0, 5'd0, 4'b0011, 1'b0, w);
        send(4'd11, 4'd0, 5'd0, 4'b0100, 1'b0, w);
        check("single_full_rate", w, 0);
        drain();

        // Async reset in the middle of a 31-beat run.
        base = n_beats;
        send(4'd0, 4'd9, 5'd31, 4'b1110, 1'b0, w);
        w = 0;
        while ((n_beats - base) < 5 && w < 100) begin
            @(posedge clk);
            #2;
            w++;
        end
        check("rst_mid_reached", (n_beats - base) >= 5, 1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_aluop", aluop, 0);
        check("rst_mid_last", last, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 1);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 0);
        end
        check("rst_rel_in_ready", in_ready, 1);
        mon_en = 1'b1;

        // Legacy single-beat instance with 6-bit opcode.
        @(negedge clk);
        check("leg_in_ready", in_ready2, 1);
        op2 = 6'd0; func2 = 4'd10; count2 = 5'd7; in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        @(negedge clk);
        check("leg_shift_valid", out_valid2, 1);
        check("leg_shift_aluop", aluop2, 4'b1110);
        check("leg_shift_last", last2, 1);
        check("leg_shift_busy", busy2, 0);
        @(negedge clk);
        check("leg_single_beat", out_valid2, 0);
        op2 = 6'b010001; func2 = 4'd0; in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        @(negedge clk);
        check("leg_hi_valid", out_valid2, 1);
        check("leg_hi_aluop", aluop2, 4'b0000);
        check("leg_hi_illegal", illegal2, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
